// File: rtl/perceptron_weight_mem.sv
// Weight store for the perceptron training core: core port with priority, host port,
// write-back burst tracking and convergence status. Define WMEM_PARITY_EN for per-word parity.
module perceptron_weight_mem #(
    parameter int DW          = 16,
    parameter int AW          = 6,
    parameter int DEPTH       = 3,
    parameter int CONV_EPOCHS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_en_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic [DW-1:0] core_rdata_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_gnt_o,
    output logic [DW-1:0] host_rdata_o,
    output logic          host_rvalid_o,
    output logic          upd_done_o,
    output logic          changed_o,
    output logic [3:0]    stable_cnt_o,
    output logic          converged_o,
    output logic [15:0]   wr_cnt_o,
`ifdef WMEM_PARITY_EN
    input  logic          inj_par_i,
    output logic          par_err_o,
`endif
    output logic          err_addr_o
);

    // state | meaning
    // IDLE  | no write-back in progress
    // BURST | core writes streaming, burst_chg accumulating
    // CLOSE | burst ended: pulse upd_done, update changed/stable_cnt
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_CLOSE = 2'd2;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] core_rdata_q, host_rdata_q;
    logic          host_rvalid_q, changed_q, changed_d, converged_q, err_addr_q;
    logic          burst_chg_q, burst_chg_d;
    logic [3:0]    stable_q, stable_d;
    logic [15:0]   wr_cnt_q;
    logic [1:0]    state_q, state_d;

    logic          core_wr, core_rd, host_wr, host_rd, core_inr, host_inr, chg_bit;
    logic [DW-1:0] core_word, host_word, wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;

    assign host_gnt_o = host_req_i & ~core_en_i;
    assign core_wr    = core_en_i & core_we_i;
    assign core_rd    = core_en_i & ~core_we_i;
    assign host_wr    = host_gnt_o & host_we_i;
    assign host_rd    = host_gnt_o & ~host_we_i;
    assign core_inr   = core_addr_i < AW'(DEPTH);
    assign host_inr   = host_addr_i < AW'(DEPTH);

    // Read mux compares full addresses so out-of-range words read as zero.
    always_comb begin
        core_word = '0;
        host_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (core_addr_i == AW'(i)) core_word = mem_q[i];
            if (host_addr_i == AW'(i)) host_word = mem_q[i];
        end
    end

    // Grant is exclusive, so at most one port writes per cycle.
    assign wr_en   = (core_wr & core_inr) | (host_wr & host_inr);
    assign wr_addr = core_en_i ? core_addr_i  : host_addr_i;
    assign wr_data = core_en_i ? core_wdata_i : host_wdata_i;
    assign chg_bit = core_wr & core_inr & (core_wdata_i != core_word);

    always_comb begin
        state_d     = state_q;
        burst_chg_d = burst_chg_q;
        changed_d   = changed_q;
        stable_d    = stable_q;
        case (state_q)
            ST_IDLE: begin
                if (core_wr) begin
                    state_d     = ST_BURST;
                    burst_chg_d = chg_bit;
                end
            end
            ST_BURST: begin
                if (core_wr) burst_chg_d = burst_chg_q | chg_bit;
                else         state_d     = ST_CLOSE;
            end
            ST_CLOSE: begin
                changed_d = burst_chg_q;
                if (burst_chg_q)            stable_d = 4'd0;
                else if (stable_q != 4'hF)  stable_d = stable_q + 4'd1;
                if (core_wr) begin
                    state_d     = ST_BURST;
                    burst_chg_d = chg_bit;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            core_rdata_q  <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            changed_q     <= 1'b0;
            stable_q      <= 4'd0;
            converged_q   <= 1'b0;
            wr_cnt_q      <= 16'd0;
            err_addr_q    <= 1'b0;
            burst_chg_q   <= 1'b0;
            state_q       <= ST_IDLE;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_addr == AW'(i)) mem_q[i] <= wr_data;
            end
            if (core_en_i) begin
                if (!core_inr)      core_rdata_q <= '0;
                else if (core_we_i) core_rdata_q <= core_wdata_i;
                else                core_rdata_q <= core_word;
            end
            host_rvalid_q <= host_rd;
            if (host_rd) host_rdata_q <= host_word;
            if (core_wr && core_inr && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            if ((core_en_i && !core_inr) || (host_gnt_o && !host_inr)) err_addr_q <= 1'b1;
            converged_q <= stable_q >= 4'(CONV_EPOCHS);
            changed_q   <= changed_d;
            stable_q    <= stable_d;
            burst_chg_q <= burst_chg_d;
            state_q     <= state_d;
        end
    end

`ifdef WMEM_PARITY_EN
    logic par_q [DEPTH];
    logic par_err_q, core_par, host_par, par_bad;

    always_comb begin
        core_par = 1'b0;
        host_par = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (core_addr_i == AW'(i)) core_par = par_q[i];
            if (host_addr_i == AW'(i)) host_par = par_q[i];
        end
    end

    assign par_bad = (core_rd && core_inr && ((^core_word) != core_par)) ||
                     (host_rd && host_inr && ((^host_word) != host_par));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_addr == AW'(i)) par_q[i] <= (^wr_data) ^ inj_par_i;
            end
            if (par_bad) par_err_q <= 1'b1;
        end
    end

    assign par_err_o = par_err_q;
`endif

    assign core_rdata_o  = core_rdata_q;
    assign host_rdata_o  = host_rdata_q;
    assign host_rvalid_o = host_rvalid_q;
    assign upd_done_o    = (state_q == ST_CLOSE);
    assign changed_o     = changed_q;
    assign stable_cnt_o  = stable_q;
    assign converged_o   = converged_q;
    assign wr_cnt_o      = wr_cnt_q;
    assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_perceptron_weight_mem.sv
// Scoreboard bench for perceptron_weight_mem: drivers push expected responses,
// monitors pop and compare when the DUT presents read data or closes a burst.
module tb_perceptron_weight_mem;

    logic        clk, rst;
    logic        core_en, core_we, host_req, host_we;
    logic [5:0]  core_addr, host_addr;
    logic [15:0] core_wdata, host_wdata;
    logic [15:0] core_rdata, host_rdata, wr_cnt;
    logic        host_gnt, host_rvalid, upd_done, changed, converged, err_addr;
    logic [3:0]  stable_cnt;
`ifdef WMEM_PARITY_EN
    logic        inj_par, par_err;
`endif

    perceptron_weight_mem dut (
        .clk(clk), .rst(rst),
        .core_en_i(core_en), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_rdata_o(core_rdata),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rdata_o(host_rdata),
        .host_rvalid_o(host_rvalid), .upd_done_o(upd_done), .changed_o(changed),
        .stable_cnt_o(stable_cnt), .converged_o(converged), .wr_cnt_o(wr_cnt),
`ifdef WMEM_PARITY_EN
        .inj_par_i(inj_par), .par_err_o(par_err),
`endif
        .err_addr_o(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        chg;
        logic [3:0]  stb;
        logic [15:0] wr;
    } upd_t;

    logic [15:0] core_q [$];
    logic [15:0] host_q [$];
    upd_t        upd_q  [$];

    int n_cmp = 0;
    int n_bad = 0;

    // expectation model
    logic [15:0] m_mem [3];
    int          m_wr, m_stb;
    logic        m_chg;
    logic        core_vld_tb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_en = 0; core_we = 0; host_req = 0; host_we = 0;
    endtask

    task automatic host_wr(input int a, input logic [15:0] d);
        idle();
        host_req = 1; host_we = 1; host_addr = 6'(a); host_wdata = d;
        #1 chk("host_gnt_wr", 32'(host_gnt), 32'd1);
        if (a < 3) m_mem[a] = d;
        cyc();
        idle();
    endtask

    task automatic host_rd(input int a);
        idle();
        host_req = 1; host_we = 0; host_addr = 6'(a);
        #1 chk("host_gnt_rd", 32'(host_gnt), 32'd1);
        host_q.push_back(a < 3 ? m_mem[a] : 16'h0);
        cyc();
        idle();
    endtask

    task automatic core_rd(input int a);
        core_en = 1; core_we = 0; core_addr = 6'(a);
        core_q.push_back(a < 3 ? m_mem[a] : 16'h0);
        cyc();
    endtask

    task automatic core_wr(input int a, input logic [15:0] d);
        core_en = 1; core_we = 1; core_addr = 6'(a); core_wdata = d;
        core_q.push_back(a < 3 ? d : 16'h0);
        if (a < 3) begin
            m_chg = m_chg | (m_mem[a] != d);
            m_mem[a] = d;
            m_wr++;
        end
        cyc();
    endtask

    task automatic end_burst();
        upd_t e;
        idle();
        m_stb = m_chg ? 0 : ((m_stb == 15) ? 15 : m_stb + 1);
        e.chg = m_chg; e.stb = 4'(m_stb); e.wr = 16'(m_wr);
        upd_q.push_back(e);
        m_chg = 0;
        repeat (4) cyc();
    endtask

    always @(posedge clk) core_vld_tb <= core_en && !rst;

    // read-data monitor
    always @(negedge clk) begin
        if (core_vld_tb) begin
            if (core_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL core_rdata: unexpected update %h", core_rdata);
            end else chk("core_rdata", 32'(core_rdata), 32'(core_q.pop_front()));
        end
        if (host_rvalid === 1'b1) begin
            if (host_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL host_rvalid: unexpected pulse, got 1 expected 0");
            end else chk("host_rdata", 32'(host_rdata), 32'(host_q.pop_front()));
        end
    end

    // burst-close monitor
    always begin
        upd_t e;
        @(negedge clk);
        if (upd_done === 1'b1) begin
            if (upd_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL upd_done: unexpected pulse, got 1 expected 0");
            end else begin
                e = upd_q.pop_front();
                @(negedge clk);
                chk("changed", 32'(changed), 32'(e.chg));
                chk("stable_cnt", 32'(stable_cnt), 32'(e.stb));
                chk("wr_cnt", 32'(wr_cnt), 32'(e.wr));
                @(negedge clk);
                chk("converged", 32'(converged), (e.stb >= 4) ? 32'd1 : 32'd0);
            end
        end
    end

    initial begin
        rst = 1; idle();
        core_addr = 0; core_wdata = 0; host_addr = 0; host_wdata = 0;
`ifdef WMEM_PARITY_EN
        inj_par = 0;
`endif
        for (int i = 0; i < 3; i++) m_mem[i] = 16'h0;
        m_wr = 0; m_stb = 0; m_chg = 0;
        repeat (3) cyc();
        chk("rst_core_rdata", 32'(core_rdata), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_upd_done", 32'(upd_done), 32'd0);
        chk("rst_stable_cnt", 32'(stable_cnt), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        rst = 0;
        cyc();

        // host preload and readback
        host_wr(0, 16'h0100);
        host_wr(1, 16'hFF00);
        host_wr(2, 16'h0020);
        for (int i = 0; i < 3; i++) host_rd(i);
        repeat (2) cyc();

        // core read blocks a concurrent host request
        host_req = 1; host_we = 0; host_addr = 6'd0;
        core_en = 1; core_we = 0; core_addr = 6'd1;
        #1 chk("host_gnt_blocked", 32'(host_gnt), 32'd0);
        core_q.push_back(16'hFF00);
        cyc();
        idle();
        repeat (3) cyc();

        // changing burst, then four identical ones, then one with a single change
        core_wr(2, 16'h0030); core_wr(1, 16'hFE00); core_wr(0, 16'h0101);
        end_burst();
        for (int b = 0; b < 4; b++) begin
            core_wr(2, 16'h0030); core_wr(1, 16'hFE00); core_wr(0, 16'h0101);
            end_burst();
        end
        chk("converged_after4", 32'(converged), 32'd1);
        core_wr(2, 16'h0030); core_wr(1, 16'hFE00); core_wr(0, 16'h0102);
        end_burst();
        chk("converged_dropped", 32'(converged), 32'd0);

        // out-of-range accesses
        core_wr(5, 16'hDEAD);
        end_burst();
        chk("err_addr_set", 32'(err_addr), 32'd1);
        host_rd(7);
        for (int i = 0; i < 3; i++) host_rd(i);
        repeat (2) cyc();

        // reset during the second cycle of a burst
        core_wr(0, 16'h1234);
        core_addr = 6'd1; core_wdata = 16'h5678; rst = 1;
        for (int i = 0; i < 3; i++) m_mem[i] = 16'h0;
        m_wr = 0; m_stb = 0; m_chg = 0;
        cyc();
        rst = 0; idle();
        repeat (4) cyc();
        chk("rst2_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst2_stable_cnt", 32'(stable_cnt), 32'd0);
        chk("rst2_err_addr", 32'(err_addr), 32'd0);
        chk("rst2_changed", 32'(changed), 32'd0);
        for (int i = 0; i < 3; i++) host_rd(i);
        repeat (4) cyc();

        chk("core_q_drained", 32'(core_q.size()), 32'd0);
        chk("host_q_drained", 32'(host_q.size()), 32'd0);
        chk("upd_q_drained", 32'(upd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
